// File: rtl/dmem_arbiter_if.sv
// Port bundles for the data-memory arbiter.
//
// dmem_arbiter_if carries one requester's port. Handshake: the requester
// raises req together with a stable {we, amp, addr, wdata} payload and holds
// all of them until it sees gnt high in the same cycle. The payload is
// sampled only in that grant cycle. Reads return data later as a one-cycle
// rvalid pulse with rdata. rdata keeps its value until the next read for the
// same requester.
//
// dmem_ram_if carries the single-port memory. The arbiter drives
// we/amp/addr/wdata, and the memory returns rdata combinationally from addr.

interface dmem_arbiter_if #(
  parameter int AW = 7,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [3:0]    amp;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output req, we, amp, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, amp, addr, wdata, output gnt, rvalid, rdata);
endinterface

interface dmem_ram_if #(
  parameter int AW = 7,
  parameter int DW = 32
);
  logic          we;
  logic [3:0]    amp;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  modport master (output we, amp, addr, wdata, input rdata);
  modport slave  (input we, amp, addr, wdata, output rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master arbiter and sequencer for the single-port data memory.
// Master 0 is the CPU data port. Master 1 is the debug/loader port.
// The arbiter accepts one transaction per two cycles. It grants in IDLE and
// drives the memory for exactly one ACCESS cycle. Read data returns on the
// cycle after ACCESS as a registered rvalid pulse.
// When both masters request, a round-robin pointer decides the winner. The
// pointer moves only on contended grants.

module dmem_arbiter #(
  parameter int AW = 7,
  parameter int DW = 32
) (
  input  logic           clk,
  input  logic           rstn,
  dmem_arbiter_if.slave  m0,
  dmem_arbiter_if.slave  m1,
  dmem_ram_if.master     ram,
  output logic           busy,
  output logic           dbg_state_o,
  output logic           dbg_ptr_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t        state_q;
  // ptr_q = 0: master 0 wins the next contended grant. ptr_q = 1: master 1 wins.
  logic          ptr_q;

  // The command register holds the accepted transaction for its ACCESS cycle.
  logic          cmd_owner_q;
  logic          cmd_we_q;
  logic [AW-1:0] cmd_addr_q;
  logic [DW-1:0] cmd_wdata_q;

  // Memory strobes are registered so they are low outside ACCESS.
  // Because the reset is asynchronous, they also drop as soon as reset asserts.
  logic          ram_we_q;
  logic [3:0]    ram_amp_q;
  logic          busy_q;

  // Per-master read return registers.
  logic          rvalid0_q;
  logic          rvalid1_q;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;

  // Arbitration signals.
  logic          can_grant;
  logic          contend;
  logic          gnt0;
  logic          gnt1;
  logic          any_gnt;
  logic          win;
  logic          sel_we;
  logic [3:0]    sel_amp;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // Grant is combinational from req and state.
  // It is held off while reset is asserted, so no grant appears during reset.
  always_comb begin
    can_grant = (state_q == IDLE) && rstn;
    contend   = m0.req && m1.req;
    gnt0      = can_grant && m0.req && (!m1.req || !ptr_q);
    gnt1      = can_grant && m1.req && (!m0.req ||  ptr_q);
    any_gnt   = gnt0 || gnt1;
    win       = gnt1;
    if (win) begin
      sel_we    = m1.we;
      sel_amp   = m1.amp;
      sel_addr  = m1.addr;
      sel_wdata = m1.wdata;
    end else begin
      sel_we    = m0.we;
      sel_amp   = m0.amp;
      sel_addr  = m0.addr;
      sel_wdata = m0.wdata;
    end
  end

  // Sequencer FSM.
  // In IDLE it latches the winning command and moves to ACCESS.
  // In ACCESS it returns read data to the owner and goes back to IDLE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      cmd_owner_q <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      ram_amp_q   <= 4'b0000;
      busy_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      // rvalid is a single-cycle pulse unless ACCESS sets it again below.
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_gnt) begin
            cmd_owner_q <= win;
            cmd_we_q    <= sel_we;
            cmd_addr_q  <= sel_addr;
            cmd_wdata_q <= sel_wdata;
            // A write with no byte enables still takes an ACCESS cycle,
            // but it never strobes the memory.
            ram_we_q    <= sel_we && (sel_amp != 4'b0000);
            ram_amp_q   <= sel_amp;
            busy_q      <= 1'b1;
            state_q     <= ACCESS;
            if (contend) begin
              ptr_q <= ~win;
            end
          end
        end
        ACCESS: begin
          if (!cmd_we_q) begin
            if (cmd_owner_q) begin
              rdata1_q  <= ram.rdata;
              rvalid1_q <= 1'b1;
            end else begin
              rdata0_q  <= ram.rdata;
              rvalid0_q <= 1'b1;
            end
          end
          ram_we_q  <= 1'b0;
          ram_amp_q <= 4'b0000;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Output wiring. ram_addr and ram_wdata hold the last command outside ACCESS.
  assign m0.gnt      = gnt0;
  assign m1.gnt      = gnt1;
  assign m0.rvalid   = rvalid0_q;
  assign m1.rvalid   = rvalid1_q;
  assign m0.rdata    = rdata0_q;
  assign m1.rdata    = rdata1_q;
  assign ram.we      = ram_we_q;
  assign ram.amp     = ram_amp_q;
  assign ram.addr    = cmd_addr_q;
  assign ram.wdata   = cmd_wdata_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;
  assign dbg_ptr_o   = ptr_q;

  // Structural invariants: grants are exclusive, and the write strobe appears only while busy.
  always @(posedge clk) begin
    if (rstn) begin
      assert (!(gnt0 && gnt1));
      assert (!ram_we_q || busy_q);
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter and sequencer for the single-port data memory behind the MIO bus. Master 0 is the CPU data port (after MIO_BUS address decode); master 1 is a debug/loader port (switch-driven memory inspector or UART loader). The block accepts one request at a time with a req/gnt handshake, drives the memory port for exactly one cycle per transaction, and returns read data with a registered valid pulse. Round-robin priority under contention.

## Interface
- AW, 7, word address width of dmem port
- DW, 32, data width
- clk  in  1  clock (same clock as dmem, Clk_CPU domain)
- rstn  in  1  asynchronous active-low reset
- m0_req  in  1  master 0 request, held until m0_gnt
- m0_we  in  1  master 0 write (1) / read (0)
- m0_amp  in  4  master 0 byte enables
- m0_addr  in  AW  master 0 word address
- m0_wdata  in  DW  master 0 write data
- m0_gnt  out  1  master 0 request accepted this cycle
- m0_rvalid  out  1  master 0 read data valid (one-cycle pulse)
- m0_rdata  out  DW  master 0 read data
- m1_req, m1_we, m1_amp, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as master 0, for master 1
- ram_we  out  1  memory write strobe
- ram_amp  out  4  memory byte enables
- ram_addr  out  AW  memory word address
- ram_wdata  out  DW  memory write data
- ram_rdata  in  DW  memory read data (combinational read of ram_addr)
- busy  out  1  transaction in ACCESS state

## Operation
- FSM states: IDLE, ACCESS. Reset state IDLE.
- IDLE: if any req, select winner, assert its gnt combinationally, latch {we, amp, addr, wdata, owner} into command register at clock edge, go ACCESS. No req: stay IDLE.
- ACCESS: ram_* driven from command register; ram_we = cmd_we & |cmd_amp. If read, ram_rdata sampled into owner's rdata register at end of cycle and owner's rvalid set for the next cycle. Always return to IDLE.
- gnt only ever asserted in IDLE; never both gnt in one cycle.
- Arbitration: only one req -> that master wins. Both req -> master indicated by priority pointer wins; pointer then points to the other master. Pointer updates only on contended grants. Pointer resets to master 0.
- Write with amp = 0: accepted and granted, occupies ACCESS, ram_we stays 0.
- Writes produce no rvalid. m*_rdata holds last read value until next read for that master.
- Outside ACCESS: ram_we = 0, ram_amp = 0; ram_addr/ram_wdata hold last command values.
- Requesters must keep req and payload stable until gnt; payload only sampled in grant cycle.

## Timing
- Reset values: m0_gnt=m1_gnt=0, m0_rvalid=m1_rvalid=0, m0_rdata=m1_rdata=0, ram_we=0, ram_amp=0, ram_addr=0, ram_wdata=0, busy=0, pointer=master 0, state IDLE.
- Cycle A: req seen in IDLE, gnt high in A (combinational from req and state).
- Cycle A+1: ACCESS, busy=1, memory write occurs on the closing edge of A+1.
- Cycle A+2: rvalid high for one cycle with rdata (reads); state IDLE, next gnt possible in A+2.
- Throughput: one transaction per 2 cycles; back-to-back contended requests alternate masters every 2 cycles.
- Reset asserted mid-ACCESS: transaction aborted, ram_we drops asynchronously, no rvalid issued after reset release.
- Request deasserted in ACCESS has no effect on in-flight transaction.

## Test plan
- Reset: rstn=0 with m0_req=1 -> all outputs 0, no gnt; release -> m0_gnt in first IDLE cycle.
- Single read: mem[5]=0xDEADBEEF, m0 read addr 5 at cycle A -> m0_gnt@A, ram_addr=5@A+1, m0_rvalid=1 and m0_rdata=0xDEADBEEF@A+2 only.
- Byte write: m1 write addr 9, amp=4'b0010, wdata=0x0000AB00 -> ram_we=1, ram_amp=0010@A+1; subsequent read of addr 9 returns byte1=0xAB, others unchanged; no rvalid for the write.
- Contention: both req held continuously from reset release -> grants m0, m1, m0, m1 on cycles 0, 2, 4, 6; never both gnt.
- Zero-byte write: m0 write amp=0 -> m0_gnt, busy for one cycle, ram_we stays 0, memory unchanged.
- Reset mid-transaction: pulse rstn low during ACCESS of an m1 read -> no m1_rvalid, m1_rdata=0, pointer back to master 0.
